uart_tx: RTL and testbench

UART transmit path. It is the serializing counterpart of the UART RX path in the same system.
- Accepts a parallel byte with a single-cycle valid strobe.
- Frames it as start bit, 8 data bits LSB-first, optional parity bit, stop bit.
- Drives the serial line at one bit per CLK cycle. CLK is the TX baud clock, generated upstream by the clock divider.
- Sits between the TX async FIFO read side (or system controller) and the UART pin.

---
 rtl/uart_tx.sv | 168 ++++++++++++++++
 tb/tb_uart_tx.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmit serializer: start bit, DATA_WIDTH data bits LSB-first, optional parity, stop bit(s).
// Optional macro UART_TX_TWO_STOP_EN adds the STOP2 input, which selects a two-cycle stop bit per frame.
module uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
`ifdef UART_TX_TWO_STOP_EN
  input  logic                  STOP2,
`endif
  output logic                  TX_OUT,
  output logic                  BUSY
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } txState_t;

  localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(DATA_WIDTH - 1);

  txState_t              r_state;
  logic                  r_txOut;
  logic                  r_busy;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [CNT_WIDTH-1:0]  r_count;
  logic                  r_parEn;
  logic                  r_parity;

  txState_t              w_nextState;
  logic                  w_nextTx;
  logic                  w_nextBusy;
  logic [DATA_WIDTH-1:0] w_nextShift;
  logic [CNT_WIDTH-1:0]  w_nextCount;
  logic                  w_nextParEn;
  logic                  w_nextParity;
  logic                  w_stopLast;
  logic                  w_accept;

`ifdef UART_TX_TWO_STOP_EN
  logic                  r_stop2;
  logic                  r_stopSecond;
  logic                  w_nextStop2;
  logic                  w_nextStopSecond;
`endif

  // State and the line itself are registered together so TX_OUT/BUSY come straight off flops.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= IDLE;
      r_txOut      <= 1'b1;
      r_busy       <= 1'b0;
      r_shift      <= '0;
      r_count      <= '0;
      r_parEn      <= 1'b0;
      r_parity     <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      r_stop2      <= 1'b0;
      r_stopSecond <= 1'b0;
`endif
    end else begin
      r_state      <= w_nextState;
      r_txOut      <= w_nextTx;
      r_busy       <= w_nextBusy;
      r_shift      <= w_nextShift;
      r_count      <= w_nextCount;
      r_parEn      <= w_nextParEn;
      r_parity     <= w_nextParity;
`ifdef UART_TX_TWO_STOP_EN
      r_stop2      <= w_nextStop2;
      r_stopSecond <= w_nextStopSecond;
`endif
    end
  end

  // Outputs are computed for the cycle being entered, i.e. what the line shows after the edge.
  always_comb begin
    w_nextState  = r_state;
    w_nextTx     = r_txOut;
    w_nextBusy   = r_busy;
    w_nextShift  = r_shift;
    w_nextCount  = r_count;
    w_nextParEn  = r_parEn;
    w_nextParity = r_parity;
    w_stopLast   = 1'b1;
`ifdef UART_TX_TWO_STOP_EN
    w_nextStop2      = r_stop2;
    w_nextStopSecond = r_stopSecond;
    w_stopLast       = !r_stop2 || r_stopSecond;
`endif
    w_accept = DATA_VALID && ((r_state == IDLE) || ((r_state == STOP) && w_stopLast));

    if (w_accept) begin
      w_nextState  = START;
      w_nextTx     = 1'b0;
      w_nextBusy   = 1'b1;
      w_nextShift  = P_DATA;
      w_nextCount  = '0;
      w_nextParEn  = PAR_EN;
      w_nextParity = (^P_DATA) ^ PAR_TYP;
`ifdef UART_TX_TWO_STOP_EN
      w_nextStop2      = STOP2;
      w_nextStopSecond = 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          w_nextTx   = 1'b1;
          w_nextBusy = 1'b0;
        end
        START: begin
          w_nextState = DATA;
          w_nextTx    = r_shift[0];
          w_nextShift = r_shift >> 1;
          w_nextCount = '0;
        end
        DATA: begin
          if (r_count == LAST_BIT) begin
            if (r_parEn) begin
              w_nextState = PARITY;
              w_nextTx    = r_parity;
            end else begin
              w_nextState = STOP;
              w_nextTx    = 1'b1;
            end
          end else begin
            w_nextCount = r_count + CNT_WIDTH'(1);
            w_nextTx    = r_shift[0];
            w_nextShift = r_shift >> 1;
          end
        end
        PARITY: begin
          w_nextState = STOP;
          w_nextTx    = 1'b1;
        end
        STOP: begin
          if (!w_stopLast) begin
`ifdef UART_TX_TWO_STOP_EN
            w_nextStopSecond = 1'b1;
`endif
            w_nextTx = 1'b1;
          end else begin
            w_nextState = IDLE;
            w_nextTx    = 1'b1;
            w_nextBusy  = 1'b0;
          end
        end
        default: begin
          w_nextState = IDLE;
          w_nextTx    = 1'b1;
          w_nextBusy  = 1'b0;
        end
      endcase
    end
  end

  assign TX_OUT = r_txOut;
  assign BUSY   = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a queue of expected line bits is rebuilt from each accepted byte
// and compared against TX_OUT/BUSY every cycle, with directed frames followed by random traffic.
module tb_uart_tx;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       stop2;
  logic       TX_OUT;
  logic       BUSY;

  int checks = 0;
  int errors = 0;
  bit expQ[$];

  uart_tx #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
`ifdef UART_TX_TWO_STOP_EN
    .STOP2     (stop2),
`endif
    .TX_OUT    (TX_OUT),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // A frame is just the list of line levels: start, data LSB-first, optional parity, stop bit(s).
  function automatic void buildFrame(input logic [7:0] d, input bit pe, input bit pt, input bit s2);
    expQ.push_back(1'b0);
    for (int i = 0; i < 8; i++) expQ.push_back(d[i]);
    if (pe) expQ.push_back((^d) ^ pt);
    expQ.push_back(1'b1);
    if (s2) expQ.push_back(1'b1);
  endfunction

  // One baud cycle: drive at the falling edge, update the model at the rising edge, check just after.
  task automatic applyStimulus(input bit dv, input logic [7:0] d, input bit pe, input bit pt,
                               input bit s2, input string tag);
    bit accept;
    bit effS2;
    @(negedge CLK);
    RST        = 1'b1;
    DATA_VALID = dv;
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    stop2      = s2;
`ifdef UART_TX_TWO_STOP_EN
    effS2 = s2;
`else
    effS2 = 1'b0;
`endif
    @(posedge CLK);
    accept = dv && (expQ.size() <= 1);
    if (expQ.size() > 0) void'(expQ.pop_front());
    if (accept) buildFrame(d, pe, pt, effS2);
    #1;
    checkOutput({tag, " tx"}, {7'd0, TX_OUT}, (expQ.size() != 0) ? {7'd0, expQ[0]} : 8'd1);
    checkOutput({tag, " busy"}, {7'd0, BUSY}, {7'd0, expQ.size() != 0});
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    RST        = 1'b0;
    P_DATA     = 8'h00;
    DATA_VALID = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    stop2      = 1'b0;
    #12;
    checkOutput("reset tx", {7'd0, TX_OUT}, 8'd1);
    checkOutput("reset busy", {7'd0, BUSY}, 8'd0);

    idle(3, "idle");

    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, "a5 nopar");
    idle(12, "a5 nopar");
    applyStimulus(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, "a5 even");
    idle(13, "a5 even");
    applyStimulus(1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, "a5 odd");
    idle(13, "a5 odd");
    applyStimulus(1'b1, 8'h01, 1'b1, 1'b0, 1'b0, "01 even");
    idle(13, "01 even");

    // Second byte offered exactly on the stop cycle of the first, then a stray byte mid-frame.
    applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, "b2b first");
    idle(9, "b2b first");
    applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, "b2b second");
    idle(3, "b2b second");
    applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, "ignored ff");
    idle(15, "after ff");

`ifdef UART_TX_TWO_STOP_EN
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, "two stop");
    idle(13, "two stop");
`endif

    // Asynchronous reset in the middle of data bits of an all-zero byte.
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, "pre reset");
    idle(4, "pre reset");
    #2;
    RST = 1'b0;
    #1;
    checkOutput("async reset tx", {7'd0, TX_OUT}, 8'd1);
    checkOutput("async reset busy", {7'd0, BUSY}, 8'd0);
    expQ.delete();
    idle(20, "post reset idle");

    // Accept on the very first edge after reset release.
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, "pre reset2");
    idle(3, "pre reset2");
    #2;
    RST = 1'b0;
    #1;
    checkOutput("async reset2 tx", {7'd0, TX_OUT}, 8'd1);
    expQ.delete();
    applyStimulus(1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, "first edge accept");
    idle(12, "first edge accept");

    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 3) == 0, 8'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), "random");
    end
    idle(14, "drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
